// File: rtl/map_query_arbiter.sv
// -----------------------------------------------------------------------------
// map_query_arbiter
//
// Purpose
//   Lets NREQ requesters (index 0 = player, then the ants) share one
//   registered map-cell lookup port. The winning requester's pixel coordinates
//   are turned into a tile column and row (TILE_PX pixels per tile) and checked
//   against the grid. One lookup is issued and the cell bit is returned to the
//   winner. Each query runs IDLE -> ISSUE -> WAIT -> RESP, so the port handles
//   at most one query every 4 cycles.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-low reset
//   i_req          per-requester request (level, held until ack)
//   i_req_x/y      packed pixel coords; requester i at [i*COORD_W +: COORD_W]
//   o_ack          one-hot, 1-cycle response strobe (during RESP)
//   o_resp_cell    map bit of the acked query (0 when out of bounds)
//   o_resp_oob     acked query was outside the grid
//   o_busy         high in every state except IDLE
//   o_lk_valid     lookup strobe to the map ROM (during ISSUE, in-bounds only)
//   o_lk_col/row   latched tile column/row of the current or last grant
//   i_lk_cell      ROM data, valid the cycle after o_lk_valid
//
// Configuration
//   MAPQ_FIXED_PRIORITY_EN : when defined, the lowest requesting index wins
//   every decision and no round-robin pointer is built. When undefined, a
//   round-robin pointer rotates the search start past the last winner.
// -----------------------------------------------------------------------------
module map_query_arbiter #(
  parameter int NREQ    = 3,
  parameter int COORD_W = 11,
  parameter int TILE_PX = 60,
  parameter int COLS    = 14,
  parameter int ROWS    = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NREQ-1:0]           i_req,
  input  logic [NREQ*COORD_W-1:0]   i_req_x,
  input  logic [NREQ*COORD_W-1:0]   i_req_y,
  output logic [NREQ-1:0]           o_ack,
  output logic                      o_resp_cell,
  output logic                      o_resp_oob,
  output logic                      o_busy,
  output logic                      o_lk_valid,
  output logic [$clog2(COLS)-1:0]   o_lk_col,
  output logic [$clog2(ROWS)-1:0]   o_lk_row,
  input  logic                      i_lk_cell
);

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(COLS * TILE_PX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(ROWS * TILE_PX);
  localparam logic [COORD_W-1:0] TILE  = COORD_W'(TILE_PX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_gidx;
  logic                r_oob;
  logic [NREQ-1:0]     r_ack;
  logic                r_resp_cell;
  logic                r_resp_oob;
  logic                r_busy;
  logic                r_lk_valid;
  logic [COL_W-1:0]    r_lk_col;
  logic [ROW_W-1:0]    r_lk_row;

  logic                w_any;
  logic [IDX_W-1:0]    w_gidx;
  logic [COORD_W-1:0]  w_gx;
  logic [COORD_W-1:0]  w_gy;
  logic                w_oob;
  logic [COL_W-1:0]    w_col;
  logic [ROW_W-1:0]    w_row;

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
`ifdef MAPQ_FIXED_PRIORITY_EN
  // Scan high to low so the lowest requesting index is the last one written.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_any  = 1'b1;
        w_gidx = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   w_cand;

  // Visit offsets from the farthest to the nearest so the requester closest to
  // the pointer (wrapping NREQ-1 -> 0) is the last one written and wins.
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    w_cand = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(NREQ))
        w_cand = w_cand - (IDX_W+1)'(NREQ);
      if (i_req[w_cand[IDX_W-1:0]]) begin
        w_any  = 1'b1;
        w_gidx = w_cand[IDX_W-1:0];
      end
    end
  end

  // The pointer moves past the winner only when a grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_ptr <= (w_gidx == IDX_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Winner coordinates -> tile position and bounds check
  // ---------------------------------------------------------------------------
  always_comb begin
    w_gx = '0;
    w_gy = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IDX_W'(i)) begin
        w_gx = i_req_x[i*COORD_W +: COORD_W];
        w_gy = i_req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Out-of-grid coordinates still produce a truncated col/row; the ROM is
  // protected by suppressing lk_valid instead.
  assign w_col = COL_W'(w_gx / TILE);
  assign w_row = ROW_W'(w_gy / TILE);
  assign w_oob = (w_gx >= X_LIM) || (w_gy >= Y_LIM);

  // ---------------------------------------------------------------------------
  // Query FSM. Every output is a register: lk_valid is set on the grant edge
  // so it appears during ISSUE, and ack/resp are set on the WAIT edge, where
  // the ROM data answering the ISSUE strobe is present.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_gidx      <= '0;
      r_oob       <= 1'b0;
      r_ack       <= '0;
      r_resp_cell <= 1'b0;
      r_resp_oob  <= 1'b0;
      r_busy      <= 1'b0;
      r_lk_valid  <= 1'b0;
      r_lk_col    <= '0;
      r_lk_row    <= '0;
    end else begin
      r_ack      <= '0;
      r_lk_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_ISSUE;
            r_gidx     <= w_gidx;
            r_oob      <= w_oob;
            r_lk_col   <= w_col;
            r_lk_row   <= w_row;
            r_lk_valid <= !w_oob;
            r_busy     <= 1'b1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_state     <= S_RESP;
          r_resp_cell <= r_oob ? 1'b0 : i_lk_cell;
          r_resp_oob  <= r_oob;
          r_ack       <= NREQ'(1) << r_gidx;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_resp_cell = r_resp_cell;
  assign o_resp_oob  = r_resp_oob;
  assign o_busy      = r_busy;
  assign o_lk_valid  = r_lk_valid;
  assign o_lk_col    = r_lk_col;
  assign o_lk_row    = r_lk_row;

endmodule

// File: tb/tb_map_query_arbiter.sv
module tb_map_query_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [32:0] req_x, req_y;
  logic [2:0]  ack;
  logic        resp_cell, resp_oob, busy, lk_valid, lk_cell;
  logic [3:0]  lk_col;
  logic [2:0]  lk_row;

  int npass = 0;
  int ntot  = 0;

  map_query_arbiter dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_x(req_x), .i_req_y(req_y),
    .o_ack(ack), .o_resp_cell(resp_cell), .o_resp_oob(resp_oob), .o_busy(busy),
    .o_lk_valid(lk_valid), .o_lk_col(lk_col), .o_lk_row(lk_row), .i_lk_cell(lk_cell)
  );

  always #5 clk = ~clk;

  // Map ROM model: wall where col and row parities differ. When no lookup was
  // strobed it returns 1, so an out-of-bounds query must mask the ROM data.
  always @(posedge clk) lk_cell <= lk_valid ? (lk_col[0] ^ lk_row[0]) : 1'b1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_xy(input int i, input int x, input int y);
    req_x[i*11 +: 11] = 11'(x);
    req_y[i*11 +: 11] = 11'(y);
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 3'b000;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b000; req_x = '0; req_y = '0;
    tick(); tick();
    ntot++; if ({ack, resp_cell, resp_oob, busy, lk_valid} !== 7'b0)
      $display("FAIL reset_ctl got %b exp 0", {ack, resp_cell, resp_oob, busy, lk_valid}); else npass++;
    ntot++; if ({lk_col, lk_row} !== 7'b0)
      $display("FAIL reset_colrow got %h exp 0", {lk_col, lk_row}); else npass++;
    reset = 1'b1;
  endtask

  // Single query, coordinate change after grant, wall and free cells.
  task automatic test_single();
    req = 3'b001; set_xy(0, 80, 80);
    tick();  // c1
    ntot++; if ({lk_valid, busy, ack} !== 5'b11000) $display("FAIL t1_c1 got %b exp 11000", {lk_valid, busy, ack}); else npass++;
    ntot++; if (lk_col !== 4'd1 || lk_row !== 3'd1) $display("FAIL t1_colrow got %0d,%0d exp 1,1", lk_col, lk_row); else npass++;
    set_xy(0, 500, 400);
    tick();  // c2
    ntot++; if (lk_valid !== 1'b0 || lk_col !== 4'd1 || lk_row !== 3'd1)
      $display("FAIL t1_c2 got v%b %0d,%0d exp v0 1,1", lk_valid, lk_col, lk_row); else npass++;
    tick();  // c3
    ntot++; if ({ack, resp_cell, resp_oob} !== 5'b00100) $display("FAIL t1_resp got %b exp 00100", {ack, resp_cell, resp_oob}); else npass++;
    req = 3'b000;
    tick();
    ntot++; if (ack !== 3'b000 || busy !== 1'b0) $display("FAIL t1_idle got ack%b busy%b exp 0", ack, busy); else npass++;
    req = 3'b001; set_xy(0, 80, 140);  // col 1 row 2 -> wall
    tick(); tick(); tick();
    ntot++; if ({ack, resp_cell, resp_oob} !== 5'b00110) $display("FAIL t1_wall got %b exp 00110", {ack, resp_cell, resp_oob}); else npass++;
    req = 3'b000; tick();
  endtask

  // All three held: 4-cycle cadence, busy only low in IDLE.
  task automatic test_all_held();
    logic [2:0] seq[4];
    logic [2:0] ea;
    logic [3:0] ecol[4];
    logic       ecell[4];
`ifdef MAPQ_FIXED_PRIORITY_EN
    seq = '{3'b001, 3'b001, 3'b001, 3'b001};
    ecol = '{4'd0, 4'd0, 4'd0, 4'd0};
    ecell = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    ecol = '{4'd0, 4'd3, 4'd13, 4'd0};
    ecell = '{1'b0, 1'b1, 1'b0, 1'b0};
`endif
    do_reset();
    set_xy(0, 0, 0); set_xy(1, 200, 130); set_xy(2, 839, 479);
    req = 3'b111;
    for (int c = 1; c <= 16; c++) begin
      tick();
      ea = (c % 4 == 3) ? seq[c/4] : 3'b000;
      ntot++; if (ack !== ea) $display("FAIL t2_ack c%0d got %b exp %b", c, ack, ea); else npass++;
      ntot++; if (busy !== (c % 4 != 0)) $display("FAIL t2_busy c%0d got %b", c, busy); else npass++;
      ntot++; if (lk_valid !== (c % 4 == 1)) $display("FAIL t2_lkv c%0d got %b", c, lk_valid); else npass++;
      if (c % 4 == 1) begin
        ntot++; if (lk_col !== ecol[c/4]) $display("FAIL t2_col c%0d got %0d exp %0d", c, lk_col, ecol[c/4]); else npass++;
      end
      if (c % 4 == 3) begin
        ntot++; if (resp_cell !== ecell[c/4]) $display("FAIL t2_cell c%0d got %b exp %b", c, resp_cell, ecell[c/4]); else npass++;
        if (c == 15) req = 3'b000;
      end
    end
  endtask

  // Grantee drops req after grant (still acked); another drops before grant.
  task automatic test_drop();
    req = 3'b001; set_xy(0, 0, 0);
    tick();           // c1
    req = 3'b100;     // req0 released after grant, req2 appears while busy
    tick();           // c2
    req = 3'b000;     // req2 gone before any IDLE cycle
    tick();           // c3
    ntot++; if (ack !== 3'b001) $display("FAIL drop_ack got %b exp 001", ack); else npass++;
    tick(); tick();
    ntot++; if (busy !== 1'b0 || ack !== 3'b000) $display("FAIL drop_nogrant got busy%b ack%b exp 0", busy, ack); else npass++;
  endtask

  task automatic test_oob();
    req = 3'b010; set_xy(1, 100, 490);
    tick();  // c1
    ntot++; if ({lk_valid, busy} !== 2'b01 || lk_col !== 4'd1)
      $display("FAIL t3_c1 got v%b b%b col%0d exp v0 b1 col1", lk_valid, busy, lk_col); else npass++;
    tick();  // c2
    ntot++; if (lk_valid !== 1'b0) $display("FAIL t3_c2 got %b exp 0", lk_valid); else npass++;
    tick();  // c3
    ntot++; if ({ack, resp_cell, resp_oob} !== 5'b01001) $display("FAIL t3_resp got %b exp 01001", {ack, resp_cell, resp_oob}); else npass++;
    req = 3'b000; tick();
  endtask

  task automatic test_bounds();
    int xs[3] = '{839, 840, 0};
    int ys[3] = '{479, 0, 480};
    logic       ev[3] = '{1'b1, 1'b0, 1'b0};
    logic [3:0] ec[3] = '{4'd13, 4'd14, 4'd0};
    logic [2:0] er[3] = '{3'd7, 3'd0, 3'd0};
    for (int t = 0; t < 3; t++) begin
      req = 3'b001; set_xy(0, xs[t], ys[t]);
      tick();
      ntot++; if (lk_valid !== ev[t] || lk_col !== ec[t] || lk_row !== er[t])
        $display("FAIL t4_lk%0d got v%b %0d,%0d exp v%b %0d,%0d", t, lk_valid, lk_col, lk_row, ev[t], ec[t], er[t]); else npass++;
      tick(); tick();
      ntot++; if ({ack, resp_cell, resp_oob} !== {3'b001, 1'b0, !ev[t]})
        $display("FAIL t4_resp%0d got %b exp %b", t, {ack, resp_cell, resp_oob}, {3'b001, 1'b0, !ev[t]}); else npass++;
      req = 3'b000; tick();
    end
  endtask

  // Reset in WAIT aborts; the pointer (left at 1) must return to 0.
  task automatic test_reset_mid();
    set_xy(0, 0, 0); set_xy(1, 60, 0); set_xy(2, 120, 0);
    req = 3'b111;
    tick(); tick();   // c2 = WAIT
    reset = 1'b0;
    tick();           // c3
    ntot++; if ({ack, resp_cell, resp_oob, busy, lk_valid} !== 7'b0)
      $display("FAIL t5_abort got %b exp 0", {ack, resp_cell, resp_oob, busy, lk_valid}); else npass++;
    ntot++; if ({lk_col, lk_row} !== 7'b0) $display("FAIL t5_colrow got %h exp 0", {lk_col, lk_row}); else npass++;
    reset = 1'b1;
    tick(); tick();
    ntot++; if (ack !== 3'b000) $display("FAIL t5_noack got %b exp 000", ack); else npass++;
    tick();
    ntot++; if (ack !== 3'b001) $display("FAIL t5_first got %b exp 001", ack); else npass++;
    req = 3'b000; tick();
  endtask

  // req0 and req2 held; req0 dropped after the third ack.
  task automatic test_arb_mode();
    logic [2:0] seq[4];
    logic [2:0] ea;
`ifdef MAPQ_FIXED_PRIORITY_EN
    seq = '{3'b001, 3'b001, 3'b001, 3'b100};
`else
    seq = '{3'b001, 3'b100, 3'b001, 3'b100};  // pointer is 0 after previous grant of 2? no: see below
`endif
    do_reset();  // pointer 0
    set_xy(0, 0, 0); set_xy(2, 0, 0);
    req = 3'b101;
    for (int c = 1; c <= 16; c++) begin
      tick();
      ea = (c % 4 == 3) ? seq[c/4] : 3'b000;
      ntot++; if (ack !== ea) $display("FAIL t6_ack c%0d got %b exp %b", c, ack, ea); else npass++;
      if (c == 11) req = 3'b100;
      if (c == 15) req = 3'b000;
    end
  endtask

  initial begin
    req = 3'b000; req_x = '0; req_y = '0; reset = 1'b0;
    test_reset();
    test_single();
    test_all_held();
    test_drop();
    test_oob();
    test_bounds();
    test_reset_mid();
    test_arb_mode();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
